sram_like_arbiter: RTL and testbench

- Arbitrates CH_NUM CPU-side like-SRAM masters (IF fetch, EXE/MEM data, later cache refill channels) onto one slave like-SRAM port.
- Tracks up to OUTSTANDING in-flight transactions in an order FIFO so each response (data_ok/rdata) returns to the channel that issued it.
- Sits between the pipeline stages and the memory bridge in the CPU top. It replaces the fixed single-cycle inst/data SRAM pair.

---
 rtl/sram_like_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Arbiter that merges several like-SRAM masters onto one slave port.
// Request path and response path are purely combinational; the only
// state is the grant lock, the round-robin pointer and an order FIFO
// of channel indices that routes each response back to its issuer.
//
// Lock state table
//   state   | meaning
//   ST_OPEN | grant recomputed every cycle from m_req
//   ST_HELD | slave saw a request it has not accepted; grant pinned to lock_ch

module sram_like_arbiter #(
    parameter int CH_NUM      = 2,
    parameter int OUTSTANDING = 4,
    parameter int RR_MODE     = 0,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [CH_NUM-1:0]              m_req,
    input  logic [CH_NUM-1:0]              m_wr,
    input  logic [2*CH_NUM-1:0]            m_size,
    input  logic [ADDR_W*CH_NUM-1:0]       m_addr,
    input  logic [DATA_W*CH_NUM-1:0]       m_wdata,
    output logic [CH_NUM-1:0]              m_addr_ok,
    output logic [CH_NUM-1:0]              m_data_ok,
    output logic [DATA_W-1:0]              m_rdata,
    output logic                           s_req,
    output logic                           s_wr,
    output logic [1:0]                     s_size,
    output logic [ADDR_W-1:0]              s_addr,
    output logic [DATA_W-1:0]              s_wdata,
    input  logic                           s_addr_ok,
    input  logic                           s_data_ok,
    input  logic [DATA_W-1:0]              s_rdata,
    output logic [$clog2(OUTSTANDING):0]   outstanding_cnt,
    output logic                           err_unexp
);

    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int PW = $clog2(OUTSTANDING);

    typedef enum logic {ST_OPEN, ST_HELD} lock_state_t;

    lock_state_t       state_q;
    lock_state_t       state_d;
    logic [CW-1:0]     lock_ch;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     fifo_mem [OUTSTANDING];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     grant;
    logic              grant_vld;
    logic [CW:0]       rr_idx;
    logic [CW-1:0]     head;
    logic              full;
    logic              empty;
    logic              accept;
    logic              resp;

    assign full    = (outstanding_cnt == (PW+1)'(OUTSTANDING));
    assign empty   = (outstanding_cnt == '0);
    assign s_req   = grant_vld & ~full;
    assign accept  = s_req & s_addr_ok;
    assign resp    = s_data_ok & ~empty;
    assign head    = fifo_mem[rd_ptr];
    assign m_rdata = s_rdata;

    // Grant selection: pinned while held, else fixed priority or round-robin.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        rr_idx    = '0;
        if (state_q == ST_HELD) begin
            grant     = lock_ch;
            grant_vld = 1'b1;
        end else if (RR_MODE == 0) begin
            for (int i = CH_NUM - 1; i >= 0; i--) begin
                if (m_req[i]) begin
                    grant     = CW'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            // Walk backwards so the channel closest to the pointer wins last.
            for (int i = CH_NUM - 1; i >= 0; i--) begin
                rr_idx = {1'b0, rr_ptr} + (CW+1)'(i);
                if (rr_idx >= (CW+1)'(CH_NUM)) begin
                    rr_idx = rr_idx - (CW+1)'(CH_NUM);
                end
                if (m_req[rr_idx[CW-1:0]]) begin
                    grant     = rr_idx[CW-1:0];
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // Slave request fields and per-channel strobes, muxed from the grant.
    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (grant == CW'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[i*2 +: 2];
                s_addr  = m_addr[i*ADDR_W +: ADDR_W];
                s_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
            m_addr_ok[i] = accept & (grant == CW'(i));
            m_data_ok[i] = resp & (head == CW'(i));
        end
    end

    // Lock next state: hold an unaccepted request, release on accept.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_OPEN;
        end else if (s_req) begin
            state_d = ST_HELD;
        end
    end

    // Control state: lock, round-robin pointer, FIFO pointers, count, error flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= ST_OPEN;
            lock_ch         <= '0;
            rr_ptr          <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            outstanding_cnt <= '0;
            err_unexp       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (s_req && !accept) begin
                lock_ch <= grant;
            end
            if (accept && RR_MODE != 0) begin
                rr_ptr <= (grant == CW'(CH_NUM - 1)) ? '0 : grant + 1'b1;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (resp) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !resp) begin
                outstanding_cnt <= outstanding_cnt + 1'b1;
            end else if (!accept && resp) begin
                outstanding_cnt <= outstanding_cnt - 1'b1;
            end
            if (s_data_ok && empty) begin
                err_unexp <= 1'b1;
            end
        end
    end

    // Order FIFO storage; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a fixed-priority 2-channel instance and a
// round-robin 3-channel instance, checked each cycle against a queue-based
// reference model, plus directed scenarios for ordering, lock, full,
// unexpected response and mid-operation reset.

module tb_sram_like_arbiter;

    localparam int OUTS = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic [2:0]  req   [2];
    logic [2:0]  wr    [2];
    logic [1:0]  size  [2][3];
    logic [31:0] addr  [2][3];
    logic [31:0] wdata [2][3];
    logic        s_aok [2];
    logic        s_dok [2];
    logic [31:0] s_rd  [2];

    logic [1:0]  fx_aok, fx_dok, fx_ssize;
    logic [31:0] fx_rdata, fx_saddr, fx_swdata;
    logic        fx_sreq, fx_swr, fx_err;
    logic [2:0]  fx_cnt;

    logic [2:0]  rr_aok, rr_dok, rr_cnt;
    logic [1:0]  rr_ssize;
    logic [31:0] rr_rdata, rr_saddr, rr_swdata;
    logic        rr_sreq, rr_swr, rr_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    int  exp_q0[$];
    int  exp_q1[$];
    bit  m_lock [2];
    int  m_lock_ch [2];
    int  m_ptr [2];
    bit  m_err [2];
    int  acc_ch [2];

    logic [2:0]  aok_log0[$];
    logic [2:0]  aok_log1[$];
    logic [2:0]  dok_log0[$];
    logic [31:0] rd_log0[$];

    always #5 clk = ~clk;

    sram_like_arbiter #(.CH_NUM(2), .OUTSTANDING(OUTS), .RR_MODE(0)) dut_fx (
        .clk(clk), .resetn(resetn),
        .m_req(req[0][1:0]), .m_wr(wr[0][1:0]),
        .m_size({size[0][1], size[0][0]}),
        .m_addr({addr[0][1], addr[0][0]}),
        .m_wdata({wdata[0][1], wdata[0][0]}),
        .m_addr_ok(fx_aok), .m_data_ok(fx_dok), .m_rdata(fx_rdata),
        .s_req(fx_sreq), .s_wr(fx_swr), .s_size(fx_ssize), .s_addr(fx_saddr),
        .s_wdata(fx_swdata), .s_addr_ok(s_aok[0]), .s_data_ok(s_dok[0]),
        .s_rdata(s_rd[0]), .outstanding_cnt(fx_cnt), .err_unexp(fx_err)
    );

    sram_like_arbiter #(.CH_NUM(3), .OUTSTANDING(OUTS), .RR_MODE(1)) dut_rr (
        .clk(clk), .resetn(resetn),
        .m_req(req[1]), .m_wr(wr[1]),
        .m_size({size[1][2], size[1][1], size[1][0]}),
        .m_addr({addr[1][2], addr[1][1], addr[1][0]}),
        .m_wdata({wdata[1][2], wdata[1][1], wdata[1][0]}),
        .m_addr_ok(rr_aok), .m_data_ok(rr_dok), .m_rdata(rr_rdata),
        .s_req(rr_sreq), .s_wr(rr_swr), .s_size(rr_ssize), .s_addr(rr_saddr),
        .s_wdata(rr_swdata), .s_addr_ok(s_aok[1]), .s_data_ok(s_dok[1]),
        .s_rdata(s_rd[1]), .outstanding_cnt(rr_cnt), .err_unexp(rr_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        for (int d = 0; d < 2; d++) begin
            req[d] = '0;
            wr[d]  = '0;
            for (int i = 0; i < 3; i++) begin
                size[d][i]  = '0;
                addr[d][i]  = '0;
                wdata[d][i] = '0;
            end
            s_aok[d] = 1'b0;
            s_dok[d] = 1'b0;
            s_rd[d]  = '0;
            acc_ch[d] = -1;
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic int q_head(input int d);
        return (d == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    // Predict this cycle's outputs from the rules, compare, then advance the model.
    task automatic model_step(input int d);
        int n, g, i, qs;
        bit sreq, acc, rsp;
        logic [2:0]  ob_aok, ob_dok, ob_cnt, eaok, edok;
        logic        ob_sreq, ob_swr, ob_err;
        logic [1:0]  ob_ssize;
        logic [31:0] ob_saddr, ob_swdata, ob_rdata;
        n = (d == 0) ? 2 : 3;
        acc_ch[d] = -1;
        if (!resetn) begin
            if (d == 0) exp_q0.delete(); else exp_q1.delete();
            m_lock[d] = 1'b0;
            m_ptr[d]  = 0;
            m_err[d]  = 1'b0;
            return;
        end
        if (d == 0) begin
            ob_aok = {1'b0, fx_aok}; ob_dok = {1'b0, fx_dok}; ob_cnt = fx_cnt;
            ob_sreq = fx_sreq; ob_swr = fx_swr; ob_err = fx_err; ob_ssize = fx_ssize;
            ob_saddr = fx_saddr; ob_swdata = fx_swdata; ob_rdata = fx_rdata;
        end else begin
            ob_aok = rr_aok; ob_dok = rr_dok; ob_cnt = rr_cnt;
            ob_sreq = rr_sreq; ob_swr = rr_swr; ob_err = rr_err; ob_ssize = rr_ssize;
            ob_saddr = rr_saddr; ob_swdata = rr_swdata; ob_rdata = rr_rdata;
        end
        qs = q_size(d);
        g = -1;
        if (m_lock[d]) begin
            g = m_lock_ch[d];
        end else begin
            for (int k = 0; k < n; k++) begin
                i = (d == 1) ? (m_ptr[d] + k) % n : k;
                if (g < 0 && req[d][i]) g = i;
            end
        end
        sreq = (g >= 0) && (qs < OUTS);
        check_eq($sformatf("d%0d_s_req", d), ob_sreq, sreq);
        if (sreq) begin
            check_eq($sformatf("d%0d_s_addr", d), ob_saddr, addr[d][g]);
            check_eq($sformatf("d%0d_s_wr", d), ob_swr, wr[d][g]);
            check_eq($sformatf("d%0d_s_size", d), ob_ssize, size[d][g]);
            check_eq($sformatf("d%0d_s_wdata", d), ob_swdata, wdata[d][g]);
        end
        acc  = sreq && s_aok[d];
        eaok = acc ? (3'b001 << g) : 3'b000;
        rsp  = s_dok[d] && (qs > 0);
        edok = rsp ? (3'b001 << q_head(d)) : 3'b000;
        check_eq($sformatf("d%0d_addr_ok", d), ob_aok, eaok);
        check_eq($sformatf("d%0d_data_ok", d), ob_dok, edok);
        if (rsp) check_eq($sformatf("d%0d_rdata", d), ob_rdata, s_rd[d]);
        check_eq($sformatf("d%0d_cnt", d), ob_cnt, qs);
        check_eq($sformatf("d%0d_err", d), ob_err, m_err[d]);
        if (d == 0) begin
            if (ob_aok != 0) aok_log0.push_back(ob_aok);
            if (ob_dok != 0) begin dok_log0.push_back(ob_dok); rd_log0.push_back(ob_rdata); end
        end else if (ob_aok != 0) begin
            aok_log1.push_back(ob_aok);
        end
        if (rsp) begin
            if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        end
        if (acc) begin
            if (d == 0) exp_q0.push_back(g); else exp_q1.push_back(g);
            m_lock[d] = 1'b0;
            if (d == 1) m_ptr[d] = (g + 1) % n;
            acc_ch[d] = g;
        end else if (sreq) begin
            m_lock[d]    = 1'b1;
            m_lock_ch[d] = g;
        end
        if (s_dok[d] && qs == 0) m_err[d] = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (acc_ch[d] >= 0) req[d][acc_ch[d]] = 1'b0;
        end
    endtask

    task automatic rand_drive(input int d);
        int n;
        n = (d == 0) ? 2 : 3;
        for (int i = 0; i < n; i++) begin
            if (!req[d][i] && $urandom_range(0, 99) < 50) begin
                req[d][i]   = 1'b1;
                addr[d][i]  = $urandom;
                wr[d][i]    = 1'($urandom_range(0, 1));
                size[d][i]  = 2'($urandom_range(0, 2));
                wdata[d][i] = $urandom;
            end
        end
        s_aok[d] = ($urandom_range(0, 99) < 60);
        s_dok[d] = ($urandom_range(0, 99) < 45);
        s_rd[d]  = $urandom;
    endtask

    initial begin
        drive_idle();
        resetn = 1'b0;
        repeat (2) cycle();
        resetn = 1'b1;
        #2;
        check_eq("rst_cnt", fx_cnt, 0);
        check_eq("rst_sreq", fx_sreq, 0);
        check_eq("rst_err", fx_err, 0);
        cycle();

        // two requesters, fixed priority, responses in issue order
        req[0] = 3'b011; addr[0][0] = 32'h0000_1000; addr[0][1] = 32'h0000_2000;
        s_aok[0] = 1'b1;
        cycle();
        cycle();
        s_aok[0] = 1'b0;
        s_dok[0] = 1'b1; s_rd[0] = 32'hAAAA;
        cycle();
        s_rd[0] = 32'h5555;
        cycle();
        s_dok[0] = 1'b0;
        check_eq("order_aok0", aok_log0[0], 3'b001);
        check_eq("order_aok1", aok_log0[1], 3'b010);
        check_eq("order_dok0", dok_log0[0], 3'b001);
        check_eq("order_dok1", dok_log0[1], 3'b010);
        check_eq("order_rd0", rd_log0[0], 32'hAAAA);
        check_eq("order_rd1", rd_log0[1], 32'h5555);

        // lock holds ch1 against a later ch0 request
        req[0] = 3'b010; addr[0][1] = 32'h1FC0_0000; addr[0][0] = 32'h0000_3000;
        repeat (3) cycle();
        req[0] = 3'b011;
        #2 check_eq("lock_addr", fx_saddr, 32'h1FC0_0000);
        cycle();
        s_aok[0] = 1'b1;
        #2 check_eq("lock_accept", fx_aok, 2'b10);
        cycle();
        #2 check_eq("after_lock", fx_aok, 2'b01);
        cycle();
        s_aok[0] = 1'b0; s_dok[0] = 1'b1;
        repeat (2) cycle();
        s_dok[0] = 1'b0;

        // fill to OUTS, check the full bubble
        for (int k = 0; k < OUTS; k++) begin
            req[0] = 3'b001; addr[0][0] = $urandom; s_aok[0] = 1'b1;
            cycle();
        end
        req[0] = 3'b001;
        #2;
        check_eq("full_cnt", fx_cnt, OUTS);
        check_eq("full_sreq", fx_sreq, 0);
        cycle();
        s_dok[0] = 1'b1;
        cycle();
        s_dok[0] = 1'b0;
        #2;
        check_eq("full_pop_cnt", fx_cnt, OUTS - 1);
        check_eq("full_pop_sreq", fx_sreq, 1);
        cycle();
        req[0] = 3'b000; s_aok[0] = 1'b0; s_dok[0] = 1'b1;
        repeat (OUTS) cycle();
        s_dok[0] = 1'b0;

        // round-robin with all three requesting continuously
        req[1] = 3'b111; s_aok[1] = 1'b1;
        for (int i = 0; i < 3; i++) addr[1][i] = $urandom;
        for (int k = 0; k < 6; k++) begin
            cycle();
            req[1] = 3'b111;
            s_dok[1] = 1'b1;
        end
        req[1] = 3'b000; s_aok[1] = 1'b0;
        cycle();
        s_dok[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("rr_grant%0d", k), aok_log1[k], 3'b001 << (k % 3));
        end

        // unexpected response with nothing in flight
        s_dok[0] = 1'b1;
        #2 check_eq("err_no_dok", fx_dok, 2'b00);
        cycle();
        s_dok[0] = 1'b0;
        #2 check_eq("err_set", fx_err, 1);
        cycle();
        #2 check_eq("err_sticky", fx_err, 1);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        #2 check_eq("err_clear", fx_err, 0);

        // reset with two in flight and a lock on ch0
        req[0] = 3'b010; s_aok[0] = 1'b1;
        cycle();
        req[0] = 3'b010;
        cycle();
        req[0] = 3'b001; s_aok[0] = 1'b0;
        cycle();
        #2 check_eq("mid_cnt", fx_cnt, 2);
        resetn = 1'b0; req[0] = 3'b000;
        cycle();
        resetn = 1'b1; req[0] = 3'b010; s_aok[0] = 1'b1;
        #2;
        check_eq("rst_mid_cnt", fx_cnt, 0);
        check_eq("rst_lock_clr", fx_aok, 2'b10);
        check_eq("rst_lock_addr", fx_saddr, 32'h1FC0_0000);
        cycle();
        req[0] = 3'b000; s_aok[0] = 1'b0; s_dok[0] = 1'b1; s_rd[0] = 32'h1234;
        #2 check_eq("rst_fifo_head", fx_dok, 2'b10);
        cycle();
        s_dok[0] = 1'b0;
        cycle();

        // randomized traffic on both instances
        drive_idle();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        repeat (3000) begin
            rand_drive(0);
            rand_drive(1);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
